// File: rtl/sram_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : sram_pixel_packer
// Description : Packs a stream of (pixel index, compressed colour) pairs into
//               SRAM words and writes each word through a req/grant arbiter
//               that the frame read path also uses. Nibble k of a word holds
//               the pixel whose index[1:0] = k. Used by the map/sprite loaders
//               and by in-game map updates.
//
// Ports       : i_clk, i_rst_n      clock, asynchronous active-low reset
//               i_valid / o_ready   pixel handshake (accept = both high)
//               i_pixel_index       linear pixel index
//               i_color             compressed colour nibble
//               i_flush             pulse: commit the partially filled word
//               o_flush_done        pulse: all flushed data has been written
//               o_sram_req          bus request towards the arbiter
//               i_sram_grant        bus granted (sampled only while waiting)
//               o_sram_addr/wdata   word address and write data
//               o_sram_*_n          active-low SRAM strobes (registered)
//
// Revision    : 1.0  initial release
// ============================================================================
module sram_pixel_packer #(
   parameter int COLOR_WIDTH     = 4,
   parameter int SRAM_DATA_WIDTH = 16,
   parameter int SRAM_ADDR_WIDTH = 20,
   parameter int PIX_INDEX_WIDTH = 19,
   parameter int BASE_ADDR       = 0,
   parameter int WRITE_CYCLES    = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [PIX_INDEX_WIDTH-1:0] i_pixel_index,
   input  logic [COLOR_WIDTH-1:0]     i_color,
   input  logic                       i_flush,
   output logic                       o_flush_done,
   output logic                       o_sram_req,
   input  logic                       i_sram_grant,
   output logic [SRAM_ADDR_WIDTH-1:0] o_sram_addr,
   output logic [SRAM_DATA_WIDTH-1:0] o_sram_wdata,
   output logic                       o_sram_we_n,
   output logic                       o_sram_ce_n,
   output logic                       o_sram_oe_n,
   output logic                       o_sram_lb_n,
   output logic                       o_sram_ub_n
);

   localparam int c_PIX_PER_WORD = SRAM_DATA_WIDTH / COLOR_WIDTH;
   localparam int c_NIB_W        = $clog2(c_PIX_PER_WORD);
   localparam int c_HALF         = c_PIX_PER_WORD / 2;
   localparam int c_WCNT_W       = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
   localparam logic [c_NIB_W-1:0]  c_LAST_NIB  = c_NIB_W'(c_PIX_PER_WORD - 1);
   localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(WRITE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ACCUM    = 2'd1,
      S_WAIT_GNT = 2'd2,
      S_WRITE    = 2'd3
   } state_t;

   state_t                       r_state,       w_state_nxt;
   logic [SRAM_ADDR_WIDTH-1:0]   r_acc_addr,    w_acc_addr_nxt;
   logic [SRAM_DATA_WIDTH-1:0]   r_acc_data,    w_acc_data_nxt;
   logic [c_PIX_PER_WORD-1:0]    r_acc_mask,    w_acc_mask_nxt;
   logic                         r_pend_valid,  w_pend_valid_nxt;
   logic [SRAM_ADDR_WIDTH-1:0]   r_pend_addr,   w_pend_addr_nxt;
   logic [c_NIB_W-1:0]           r_pend_nib,    w_pend_nib_nxt;
   logic [COLOR_WIDTH-1:0]       r_pend_color,  w_pend_color_nxt;
   logic                         r_flushing,    w_flushing_nxt;
   logic [c_WCNT_W-1:0]          r_wcnt,        w_wcnt_nxt;
   logic                         r_flush_done,  w_flush_done_nxt;
   logic                         r_sram_req,    w_sram_req_nxt;
   logic [SRAM_ADDR_WIDTH-1:0]   r_sram_addr,   w_sram_addr_nxt;
   logic [SRAM_DATA_WIDTH-1:0]   r_sram_wdata,  w_sram_wdata_nxt;
   logic                         r_we_n,        w_we_n_nxt;
   logic                         r_ce_n,        w_ce_n_nxt;
   logic                         r_lb_n,        w_lb_n_nxt;
   logic                         r_ub_n,        w_ub_n_nxt;

   logic                         w_accept;
   logic                         w_same_word;
   logic                         w_flush_eff;
   logic [SRAM_ADDR_WIDTH-1:0]   w_in_addr;
   logic [c_NIB_W-1:0]           w_in_nib;
   logic [c_PIX_PER_WORD-1:0]    w_in_onehot;
   logic [c_PIX_PER_WORD-1:0]    w_merge_mask;
   logic [c_PIX_PER_WORD-1:0]    w_pend_onehot;
   logic [SRAM_DATA_WIDTH-1:0]   w_in_data;
   logic [SRAM_DATA_WIDTH-1:0]   w_merge_data;
   logic [SRAM_DATA_WIDTH-1:0]   w_pend_data;

   assign o_ready   = (r_state == S_IDLE) || (r_state == S_ACCUM);
   assign w_accept  = i_valid && o_ready;
   assign w_in_nib  = i_pixel_index[c_NIB_W-1:0];
   assign w_in_addr = SRAM_ADDR_WIDTH'(BASE_ADDR)
                    + SRAM_ADDR_WIDTH'(i_pixel_index >> c_NIB_W);
   assign w_same_word  = (w_in_addr == r_acc_addr);
   assign w_merge_mask = r_acc_mask | w_in_onehot;

   // Nibble placement helpers: a freshly loaded word starts from zero so
   // unwritten nibbles go out as 0; a merge overwrites in place (last wins).
   always_comb begin
      w_in_onehot   = '0;
      w_pend_onehot = '0;
      w_in_data     = '0;
      w_pend_data   = '0;
      w_merge_data  = r_acc_data;
      w_in_onehot[w_in_nib]     = 1'b1;
      w_pend_onehot[r_pend_nib] = 1'b1;
      w_in_data[w_in_nib*COLOR_WIDTH +: COLOR_WIDTH]      = i_color;
      w_merge_data[w_in_nib*COLOR_WIDTH +: COLOR_WIDTH]   = i_color;
      w_pend_data[r_pend_nib*COLOR_WIDTH +: COLOR_WIDTH]  = r_pend_color;
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_acc_addr_nxt   = r_acc_addr;
      w_acc_data_nxt   = r_acc_data;
      w_acc_mask_nxt   = r_acc_mask;
      w_pend_valid_nxt = r_pend_valid;
      w_pend_addr_nxt  = r_pend_addr;
      w_pend_nib_nxt   = r_pend_nib;
      w_pend_color_nxt = r_pend_color;
      w_flushing_nxt   = r_flushing;
      w_wcnt_nxt       = r_wcnt;
      w_flush_done_nxt = 1'b0;
      w_flush_eff      = r_flushing || i_flush;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_acc_addr_nxt = w_in_addr;
               w_acc_data_nxt = w_in_data;
               w_acc_mask_nxt = w_in_onehot;
               w_flushing_nxt = i_flush;
               if ((w_in_nib == c_LAST_NIB) || i_flush)
                  w_state_nxt = S_WAIT_GNT;
               else
                  w_state_nxt = S_ACCUM;
            end else if (i_flush) begin
               // Nothing buffered: the flush is complete immediately.
               w_flush_done_nxt = 1'b1;
            end
         end

         S_ACCUM: begin
            if (w_accept && w_same_word) begin
               w_acc_data_nxt = w_merge_data;
               w_acc_mask_nxt = w_merge_mask;
               if ((w_in_nib == c_LAST_NIB) || (&w_merge_mask) || i_flush)
                  w_state_nxt = S_WAIT_GNT;
            end else if (w_accept) begin
               // New word: park the pixel and commit the current word.
               w_pend_valid_nxt = 1'b1;
               w_pend_addr_nxt  = w_in_addr;
               w_pend_nib_nxt   = w_in_nib;
               w_pend_color_nxt = i_color;
               w_state_nxt      = S_WAIT_GNT;
            end else if (i_flush) begin
               w_state_nxt = S_WAIT_GNT;
            end
            if (i_flush)
               w_flushing_nxt = 1'b1;
         end

         S_WAIT_GNT: begin
            w_flushing_nxt = w_flush_eff;
            if (i_sram_grant) begin
               w_state_nxt = S_WRITE;
               w_wcnt_nxt  = '0;
            end
         end

         S_WRITE: begin
            if (r_wcnt == c_WCNT_LAST) begin
               if (r_pend_valid) begin
                  w_acc_addr_nxt   = r_pend_addr;
                  w_acc_data_nxt   = w_pend_data;
                  w_acc_mask_nxt   = w_pend_onehot;
                  w_pend_valid_nxt = 1'b0;
                  w_flushing_nxt   = w_flush_eff;
                  // A pending flush covers the parked pixel as well.
                  if ((r_pend_nib == c_LAST_NIB) || w_flush_eff)
                     w_state_nxt = S_WAIT_GNT;
                  else
                     w_state_nxt = S_ACCUM;
               end else begin
                  w_state_nxt      = S_IDLE;
                  w_flushing_nxt   = 1'b0;
                  w_flush_done_nxt = w_flush_eff;
               end
            end else begin
               w_wcnt_nxt     = r_wcnt + 1'b1;
               w_flushing_nxt = w_flush_eff;
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase

      // Bus outputs are derived from the next state and registered so the
      // strobes change only on clock edges. Address and data are held after
      // a write so the bus does not move with the rising we_n.
      w_sram_req_nxt   = (w_state_nxt == S_WAIT_GNT) || (w_state_nxt == S_WRITE);
      w_we_n_nxt       = (w_state_nxt != S_WRITE);
      w_ce_n_nxt       = (w_state_nxt != S_WRITE);
      w_lb_n_nxt       = !(w_sram_req_nxt && (|w_acc_mask_nxt[c_HALF-1:0]));
      w_ub_n_nxt       = !(w_sram_req_nxt && (|w_acc_mask_nxt[c_PIX_PER_WORD-1:c_HALF]));
      w_sram_addr_nxt  = w_sram_req_nxt ? w_acc_addr_nxt : r_sram_addr;
      w_sram_wdata_nxt = w_sram_req_nxt ? w_acc_data_nxt : r_sram_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_acc_addr   <= '0;
         r_acc_data   <= '0;
         r_acc_mask   <= '0;
         r_pend_valid <= 1'b0;
         r_pend_addr  <= '0;
         r_pend_nib   <= '0;
         r_pend_color <= '0;
         r_flushing   <= 1'b0;
         r_wcnt       <= '0;
         r_flush_done <= 1'b0;
         r_sram_req   <= 1'b0;
         r_sram_addr  <= '0;
         r_sram_wdata <= '0;
         r_we_n       <= 1'b1;
         r_ce_n       <= 1'b1;
         r_lb_n       <= 1'b1;
         r_ub_n       <= 1'b1;
      end else begin
         r_state      <= w_state_nxt;
         r_acc_addr   <= w_acc_addr_nxt;
         r_acc_data   <= w_acc_data_nxt;
         r_acc_mask   <= w_acc_mask_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_pend_addr  <= w_pend_addr_nxt;
         r_pend_nib   <= w_pend_nib_nxt;
         r_pend_color <= w_pend_color_nxt;
         r_flushing   <= w_flushing_nxt;
         r_wcnt       <= w_wcnt_nxt;
         r_flush_done <= w_flush_done_nxt;
         r_sram_req   <= w_sram_req_nxt;
         r_sram_addr  <= w_sram_addr_nxt;
         r_sram_wdata <= w_sram_wdata_nxt;
         r_we_n       <= w_we_n_nxt;
         r_ce_n       <= w_ce_n_nxt;
         r_lb_n       <= w_lb_n_nxt;
         r_ub_n       <= w_ub_n_nxt;
      end
   end

   assign o_flush_done = r_flush_done;
   assign o_sram_req   = r_sram_req;
   assign o_sram_addr  = r_sram_addr;
   assign o_sram_wdata = r_sram_wdata;
   assign o_sram_we_n  = r_we_n;
   assign o_sram_ce_n  = r_ce_n;
   assign o_sram_oe_n  = 1'b1;   // write-only port: output enable never asserted
   assign o_sram_lb_n  = r_lb_n;
   assign o_sram_ub_n  = r_ub_n;

endmodule
`default_nettype wire
